// File: rtl/tile_feed_ctrl_pkg.sv
// Shared types and constants for the 4x4 tile feed controller.
package tile_feed_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int ARRAY_DIM = 4;
  // 1 SRAM cycle + (ARRAY_DIM-1) skew stages + (ARRAY_DIM-1) array hops
  localparam int FLUSH_LEN = 2 * (ARRAY_DIM - 1) + 1;
  localparam int WRITE_LEN = ARRAY_DIM;
  localparam int ROW_W     = $clog2(ARRAY_DIM);

endpackage

// File: rtl/tile_addr_gen.sv
// Address generator: loads a base address, then steps by one with
// natural wrap at ADDR_W bits. Shared by the A, B and C streams.
module tile_addr_gen
  import tile_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr
);

  // Base load has priority over increment; overflow wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/tile_feed_ctrl.sv
// Sequencing controller for one 4x4 output tile: clear, feed K operand
// words, flush the skew/array pipeline, write four result rows, pulse done.
// Optional busy-cycle counter is built when TILE_FEED_CTRL_PERF_EN is defined.
// fsm_state exposes the controller state for observation.
module tile_feed_ctrl
  import tile_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int K_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              busy,
  output logic              done,
  output logic              a_en,
  output logic              b_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              data_valid,
  output logic              buf_clr,
  output logic              pe_en,
  output logic              c_wen,
  output logic [ADDR_W-1:0] c_addr,
  output logic [1:0]        c_row_sel,
  output logic [31:0]       perf_cycles,
  output state_t            fsm_state
);

  // Handshake: start is a level sampled only while IDLE; a sampled start
  // is the accept. There is no backpressure anywhere in the datapath.

  state_t         state;
  logic [K_W-1:0] k_reg;
  logic [K_W-1:0] cnt;
  logic           accept;

  assign accept    = (state == IDLE) && start;
  assign fsm_state = state;

  tile_addr_gen #(.ADDR_W(ADDR_W)) u_a_gen (
    .clk (clk), .rst (rst), .load (accept), .inc (state == FEED),
    .base(a_base), .addr(a_addr)
  );

  tile_addr_gen #(.ADDR_W(ADDR_W)) u_b_gen (
    .clk (clk), .rst (rst), .load (accept), .inc (state == FEED),
    .base(b_base), .addr(b_addr)
  );

  tile_addr_gen #(.ADDR_W(ADDR_W)) u_c_gen (
    .clk (clk), .rst (rst), .load (accept), .inc (state == WRITE),
    .base(c_base), .addr(c_addr)
  );

  // Phase sequencer; outputs are registered and set on the edge entering
  // each phase, cnt holds the remaining cycles of the current phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_en      <= 1'b0;
      b_en      <= 1'b0;
      buf_clr   <= 1'b0;
      pe_en     <= 1'b0;
      c_wen     <= 1'b0;
      c_row_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            buf_clr <= 1'b1;
            k_reg   <= k_len;
          end
        end
        CLEAR: begin
          buf_clr <= 1'b0;
          if (k_reg == '0) begin
            // zero-length command still writes four (zero) rows
            state     <= WRITE;
            c_wen     <= 1'b1;
            c_row_sel <= '0;
            cnt       <= K_W'(WRITE_LEN - 1);
          end else begin
            state <= FEED;
            a_en  <= 1'b1;
            b_en  <= 1'b1;
            cnt   <= k_reg - K_W'(1);
          end
        end
        FEED: begin
          // PE enable follows data_valid, which lags a_en by one cycle
          pe_en <= 1'b1;
          if (cnt == '0) begin
            state <= FLUSH;
            a_en  <= 1'b0;
            b_en  <= 1'b0;
            cnt   <= K_W'(FLUSH_LEN - 1);
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state     <= WRITE;
            pe_en     <= 1'b0;
            c_wen     <= 1'b1;
            c_row_sel <= '0;
            cnt       <= K_W'(WRITE_LEN - 1);
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            state     <= DONE;
            c_wen     <= 1'b0;
            c_row_sel <= '0;
            done      <= 1'b1;
          end else begin
            cnt       <= cnt - K_W'(1);
            c_row_sel <= c_row_sel + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM read data arrives one cycle after the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= a_en;
    end
  end

`ifdef TILE_FEED_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  // Saturating busy-cycle counter; holds its final value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (accept) begin
      perf_cnt <= '0;
    end else if (busy && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_cycles = perf_cnt;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tile_feed_ctrl.sv
// Scoreboard bench for tile_feed_ctrl: each command pushes its expected
// cycle-stamped output events; a negedge monitor pops and compares them.
module tb_tile_feed_ctrl;
  import tile_feed_ctrl_pkg::*;

  localparam int ADDR_W = 16;
  localparam int K_W    = 9;
`ifdef TILE_FEED_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic              start = 1'b0;
  logic [K_W-1:0]    k_len = '0;
  logic [ADDR_W-1:0] a_base = '0, b_base = '0, c_base = '0;
  logic              busy, done, a_en, b_en, data_valid, buf_clr, pe_en, c_wen;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [1:0]        c_row_sel;
  logic [31:0]       perf_cycles;
  state_t            fsm_state;

  tile_feed_ctrl #(.ADDR_W(ADDR_W), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .a_en(a_en), .b_en(b_en),
    .a_addr(a_addr), .b_addr(b_addr), .data_valid(data_valid),
    .buf_clr(buf_clr), .pe_en(pe_en), .c_wen(c_wen), .c_addr(c_addr),
    .c_row_sel(c_row_sel), .perf_cycles(perf_cycles), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_a[$], exp_b[$], exp_dv[$], exp_pe[$];
  logic [63:0] exp_busy[$], exp_clr[$], exp_c[$], exp_done[$];

  function automatic logic [63:0] mk(int c, logic [1:0] row, logic [15:0] addr);
    return {32'(c), 14'd0, row, addr};
  endfunction

  function automatic logic [89:0] outs();
    return {busy, done, a_en, b_en, a_addr, b_addr, data_valid, buf_clr,
            pe_en, c_wen, c_addr, c_row_sel, perf_cycles};
  endfunction

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(string name, logic [95:0] act);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s actual=%0h expected=no event (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every asserted output strobe must match the next expected event.
  logic [63:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      if (a_en) begin
        if (exp_a.size() == 0) unexpected("a_rd", mk(cyc, 2'd0, a_addr));
        else begin e = exp_a.pop_front(); check("a_rd", mk(cyc, 2'd0, a_addr), e); end
      end
      if (b_en) begin
        if (exp_b.size() == 0) unexpected("b_rd", mk(cyc, 2'd0, b_addr));
        else begin e = exp_b.pop_front(); check("b_rd", mk(cyc, 2'd0, b_addr), e); end
      end
      if (data_valid) begin
        if (exp_dv.size() == 0) unexpected("data_valid", mk(cyc, 2'd0, 16'd0));
        else begin e = exp_dv.pop_front(); check("data_valid", mk(cyc, 2'd0, 16'd0), e); end
      end
      if (pe_en) begin
        if (exp_pe.size() == 0) unexpected("pe_en", mk(cyc, 2'd0, 16'd0));
        else begin e = exp_pe.pop_front(); check("pe_en", mk(cyc, 2'd0, 16'd0), e); end
      end
      if (busy) begin
        if (exp_busy.size() == 0) unexpected("busy", mk(cyc, 2'd0, 16'd0));
        else begin e = exp_busy.pop_front(); check("busy", mk(cyc, 2'd0, 16'd0), e); end
      end
      if (buf_clr) begin
        if (exp_clr.size() == 0) unexpected("buf_clr", mk(cyc, 2'd0, 16'd0));
        else begin e = exp_clr.pop_front(); check("buf_clr", mk(cyc, 2'd0, 16'd0), e); end
      end
      if (c_wen) begin
        if (exp_c.size() == 0) unexpected("c_wr", mk(cyc, c_row_sel, c_addr));
        else begin e = exp_c.pop_front(); check("c_wr", mk(cyc, c_row_sel, c_addr), e); end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done", mk(cyc, 2'd0, 16'd0));
        else begin e = exp_done.pop_front(); check("done", mk(cyc, 2'd0, 16'd0), e); end
      end
    end
  end

  // Cycle of done relative to the start-sample cycle.
  function automatic int done_rel(int k);
    return (k == 0) ? 6 : k + 13;
  endfunction

  // Push expected events for a command accepted in cycle c0; events at
  // relative cycles >= abort are dropped (command killed by reset).
  task automatic push_cmd(int c0, int k, logic [15:0] a, logic [15:0] b,
                          logic [15:0] c, int abort);
    int wr0;
    wr0 = (k == 0) ? 2 : k + 9;
    if (1 < abort) exp_clr.push_back(mk(c0 + 1, 2'd0, 16'd0));
    for (int i = 0; i < k; i++) begin
      if (2 + i < abort) begin
        exp_a.push_back(mk(c0 + 2 + i, 2'd0, a + 16'(i)));
        exp_b.push_back(mk(c0 + 2 + i, 2'd0, b + 16'(i)));
      end
    end
    for (int i = 0; i < k; i++)
      if (3 + i < abort) exp_dv.push_back(mk(c0 + 3 + i, 2'd0, 16'd0));
    if (k > 0)
      for (int r = 3; r <= k + 8; r++)
        if (r < abort) exp_pe.push_back(mk(c0 + r, 2'd0, 16'd0));
    for (int r = 1; r <= done_rel(k); r++)
      if (r < abort) exp_busy.push_back(mk(c0 + r, 2'd0, 16'd0));
    for (int r = 0; r < 4; r++)
      if (wr0 + r < abort) exp_c.push_back(mk(c0 + wr0 + r, 2'(r), c + 16'(r)));
    if (done_rel(k) < abort) exp_done.push_back(mk(c0 + done_rel(k), 2'd0, 16'd0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) next_cyc();
  endtask

  task automatic drive_cmd(int k, logic [15:0] a, logic [15:0] b, logic [15:0] c);
    k_len  = K_W'(k);
    a_base = a;
    b_base = b;
    c_base = c;
    start  = 1'b1;
  endtask

  task automatic run_cmd(string name, int k, logic [15:0] a, logic [15:0] b,
                         logic [15:0] c, int exp_perf);
    int c0;
    c0 = cyc;
    drive_cmd(k, a, b, c);
    push_cmd(c0, k, a, b, c, 1000);
    next_cyc();
    start = 1'b0;
    wait_until(c0 + done_rel(k) + 1);
    check(name, perf_cycles, PERF_ON ? 32'(exp_perf) : 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    repeat (3) next_cyc();
    check("reset_outs", 96'(outs()), 96'd0);
    check("reset_state", 96'(fsm_state), 96'(IDLE));
    rst = 1'b0;
    next_cyc();

    // basic command, zero-length command, address wrap
    run_cmd("perf_k4", 4, 16'h0010, 16'h0020, 16'h0100, 17);
    run_cmd("perf_k0", 0, 16'h1234, 16'h5678, 16'h0200, 6);
    run_cmd("perf_k3_wrap", 3, 16'hFFFE, 16'h0005, 16'hFFFD, 16);

    // start re-pulsed with different fields during FEED is ignored
    c0 = cyc;
    drive_cmd(5, 16'h0300, 16'h0400, 16'h0500);
    push_cmd(c0, 5, 16'h0300, 16'h0400, 16'h0500, 1000);
    next_cyc();
    start = 1'b0;
    wait_until(c0 + 3);
    drive_cmd(2, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    next_cyc();
    start = 1'b0;
    wait_until(c0 + done_rel(5) + 1);
    check("perf_k5_repulse", perf_cycles, PERF_ON ? 32'd18 : 32'd0);

    // start held high: second command accepted at K+14, fields latched
    c0 = cyc;
    drive_cmd(2, 16'h0040, 16'h0050, 16'h0060);
    push_cmd(c0, 2, 16'h0040, 16'h0050, 16'h0060, 1000);
    push_cmd(c0 + 16, 2, 16'h0040, 16'h0050, 16'h0060, 1000);
    wait_until(c0 + 17);
    start  = 1'b0;
    k_len  = 9'd7;
    a_base = 16'h7777;
    b_base = 16'h8888;
    c_base = 16'h9999;
    wait_until(c0 + 32);
    check("perf_k2_held", perf_cycles, PERF_ON ? 32'd15 : 32'd0);

    // reset during FLUSH kills the command; no result writes follow
    c0 = cyc;
    drive_cmd(4, 16'h0800, 16'h0900, 16'h0A00);
    push_cmd(c0, 4, 16'h0800, 16'h0900, 16'h0A00, 8);
    next_cyc();
    start = 1'b0;
    wait_until(c0 + 8);
    rst = 1'b1;
    #1;
    check("midrst_outs", 96'(outs()), 96'd0);
    check("midrst_state", 96'(fsm_state), 96'(IDLE));
    next_cyc();
    rst = 1'b0;
    repeat (20) next_cyc();
    check("busy_after_rst", 96'(busy), 96'd0);
    run_cmd("perf_after_rst", 2, 16'h0B00, 16'h0C00, 16'h0D00, 15);

    // start held through reset release begins right after deassertion
    rst = 1'b1;
    drive_cmd(1, 16'h0E00, 16'h0F00, 16'h1000);
    next_cyc();
    next_cyc();
    rst = 1'b0;
    c0 = cyc;
    push_cmd(c0, 1, 16'h0E00, 16'h0F00, 16'h1000, 1000);
    next_cyc();
    start = 1'b0;
    wait_until(c0 + done_rel(1) + 1);
    check("perf_rst_release", perf_cycles, PERF_ON ? 32'd14 : 32'd0);

    // every expected event must have been observed
    repeat (3) next_cyc();
    check("drain_a", 96'(exp_a.size()), 96'd0);
    check("drain_b", 96'(exp_b.size()), 96'd0);
    check("drain_dv", 96'(exp_dv.size()), 96'd0);
    check("drain_pe", 96'(exp_pe.size()), 96'd0);
    check("drain_busy", 96'(exp_busy.size()), 96'd0);
    check("drain_clr", 96'(exp_clr.size()), 96'd0);
    check("drain_c", 96'(exp_c.size()), 96'd0);
    check("drain_done", 96'(exp_done.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_feed_ctrl.md
# tile_feed_ctrl

Sequencing controller for one 4x4 output tile of the systolic matrix unit. On a start pulse it clears the array accumulators and streams K operand words from the A and B SRAMs into the 4-lane skew buffers. It then runs the pipeline dry, writes the four result rows to the C SRAM, and pulses done. The controller sits between the host command register and the SRAM/skew-buffer/PE datapath; it owns every enable and address in that path.

## Interface
- ADDR_W, 16, SRAM word-address width (A, B, C)
- K_W, 9, width of the K-length field; maximum K = 2^K_W − 1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command pulse; sampled only in IDLE
- k_len  in  K_W  reduction length; latched at start
- a_base / b_base / c_base  in  ADDR_W  base addresses; latched at start
- busy  out  1  high from the cycle after start through DONE
- done  out  1  one-cycle completion pulse
- a_en, b_en  out  1  SRAM read enables (read data 1-cycle latency)
- a_addr, b_addr  out  ADDR_W  read addresses
- data_valid  out  1  a_en delayed 1 cycle; datapath drives zeros into the skew buffers when low
- buf_clr  out  1  clears the skew buffers and PE accumulators
- pe_en  out  1  PE compute enable
- c_wen  out  1  result write enable
- c_addr  out  ADDR_W  result write address
- c_row_sel  out  2  selects which array row drives C write data
- perf_cycles  out  32  busy-cycle count of the last command (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, WRITE, DONE.
- IDLE → CLEAR on start. start is ignored in every other state.
- CLEAR lasts 1 cycle with buf_clr=1. Next state is FEED, or WRITE if k_len==0; a zero-length command writes four zero rows.
- FEED lasts k_len cycles. a_en=b_en=1. Addresses are base+i for i=0..k_len−1, 16-bit wrap-around with no error.
- FLUSH lasts FLUSH_LEN=7 cycles (1 SRAM + 3 skew + 3 array propagation). a_en=b_en=0.
- WRITE lasts 4 cycles with c_wen=1, c_row_sel=r, c_addr=c_base+r for r=0..3 (wrapping).
- DONE lasts 1 cycle with done=1, then returns to IDLE.
- pe_en=1 from the first data_valid cycle through the last FLUSH cycle.
- Reset mid-command: all registers and outputs go to 0 and the FSM returns to IDLE immediately. No write is completed. The next start works normally.
- Reset values: every output is 0. Latched k_len and base registers are 0.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Cycle 1: CLEAR, busy=1, buf_clr=1.
- Cycles 2..K+1: FEED. Cycles 3..K+2: data_valid=1.
- Cycles K+2..K+8: FLUSH. pe_en=1 on cycles 3..K+8.
- Cycles K+9..K+12: WRITE.
- Cycle K+13: DONE with done=1.
- Cycle K+14: IDLE with busy=0. A start in this cycle is accepted.
- Command latency is start to done = K+13 cycles.
- For K=0: CLEAR at cycle 1, WRITE on cycles 2..5, DONE at cycle 6.
- start held high is re-sampled in IDLE only, so back-to-back commands run with a single IDLE cycle between them.

## Configuration
- TILE_FEED_CTRL_PERF_EN defined: a 32-bit counter clears on the start-accept edge and increments every busy cycle. It saturates at 0xFFFFFFFF. perf_cycles holds the final count from DONE until the next start. Reset clears it.
- Macro undefined: the counter is not built and perf_cycles is tied to 0.

## Structure
- Package tile_feed_ctrl_pkg holds:
  - the state enum
  - ARRAY_DIM=4
  - FLUSH_LEN = 2·(ARRAY_DIM−1)+1
  - WRITE_LEN = ARRAY_DIM
- One sub-module, tile_addr_gen, is used for both operand streams and the result stream. It provides base load, increment, and ADDR_W wrap, and is instantiated three times (A, B, C).
- The FSM and the shared phase counter live in the top module.

## Test plan
- start with k_len=4, a_base=0x0010, b_base=0x0020, c_base=0x0100.
  - a_addr reads 0x10..0x13 and b_addr reads 0x20..0x23 on cycles 2..5.
  - c_addr writes 0x100..0x103 on cycles 13..16.
  - done=1 on cycle 17.
  - perf_cycles=17 with the macro defined, 0 without.
- k_len=0 → CLEAR, then c_wen on cycles 2..5, done on cycle 6; a_en never asserts.
- a_base=0xFFFE, k_len=3 → a_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- start re-pulsed during FEED, and held high through the whole command → no effect mid-command. The second command is accepted at cycle K+14.
- rst raised during FLUSH for one cycle → all outputs 0 asynchronously, no c_wen afterwards, busy=0. A new start with k_len=2 then completes with done at cycle 15.
- Reset release with start held high → first command begins the cycle after rst deasserts.
